// File: rtl/cache_controller.sv
// cache_controller
//   Sequencing FSM for a 4-way, NUM_SETS-set, LINE_W-bit-line cache.
//   It handles lookup, read-miss refill with tree pseudo-LRU victim selection,
//   and write-through / no-write-allocate stores. It owns the per-set PLRU
//   bits and drives the victim one-hot (lru_way) for the latched index.
//
// Ports
//   clk, reset        clock, synchronous active-high reset
//   cpu_*             CPU load/store port: req/we/addr/wdata in; busy/ack/rdata out
//   cache_*           cache block: addr/wdata/we/fill_we/fill_data out; hit/rdata in
//   hit_way, lru_way  one-hot hit way (in), one-hot victim way (out)
//   mem_*             line-granular memory: req/we/addr/wdata out; ack/rdata in
//
// Optional build macro
//   CACHE_STATS_EN    adds saturating stat_hits / stat_misses counters that
//                     count only the first LOOKUP of each request
module cache_controller #(
  parameter int ADDR_W   = 32,
  parameter int NUM_SETS = 128,
  parameter int LINE_W   = 512
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [31:0]       cpu_wdata,
  output logic              cpu_busy,
  output logic              cpu_ack,
  output logic [31:0]       cpu_rdata,
  output logic [ADDR_W-1:0] cache_addr,
  output logic [31:0]       cache_wdata,
  output logic              cache_we,
  output logic              cache_fill_we,
  output logic [LINE_W-1:0] cache_fill_data,
  output logic [3:0]        lru_way,
  input  logic              cache_hit,
  input  logic [3:0]        hit_way,
  input  logic [31:0]       cache_rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ack,
  input  logic [LINE_W-1:0] mem_rdata
`ifdef CACHE_STATS_EN
  ,
  output logic [31:0]       stat_hits,
  output logic [31:0]       stat_misses
`endif
);

  localparam int OFF_W = $clog2(LINE_W / 8);
  localparam int IDX_W = $clog2(NUM_SETS);

  typedef enum logic [2:0] {
    S_IDLE, S_LOOKUP, S_REFILL, S_FILL, S_WTHRU, S_RESP
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                we_q, we_d;
  logic [31:0]         wdata_q, wdata_d;
  logic [31:0]         rdata_q, rdata_d;
  logic [ADDR_W-1:0]   maddr_q, maddr_d;
  logic [31:0]         mwdata_q, mwdata_d;
  logic [LINE_W-1:0]   fill_q, fill_d;
  logic                post_fill_q, post_fill_d;   // current LOOKUP follows a FILL
  logic [NUM_SETS-1:0][2:0] plru_q;                 // per set {b2,b1,b0}

  logic [IDX_W-1:0] idx;
  logic [2:0]       plru_cur, plru_nxt;
  logic [1:0]       vic_enc, hit_enc, upd_way;
  logic             plru_upd;

  assign idx      = addr_q[OFF_W +: IDX_W];
  assign plru_cur = plru_q[idx];

  // b0 chooses the half, b1/b2 choose within the left/right half
  assign vic_enc = plru_cur[0] ? (plru_cur[2] ? 2'd3 : 2'd2)
                               : (plru_cur[1] ? 2'd1 : 2'd0);
  // multiple hit bits resolve to the lowest-numbered way
  assign hit_enc = hit_way[0] ? 2'd0 : hit_way[1] ? 2'd1 :
                   hit_way[2] ? 2'd2 : hit_way[3] ? 2'd3 : 2'd0;

  always_comb begin
    plru_nxt    = plru_cur;
    plru_nxt[0] = ~upd_way[1];
    if (!upd_way[1]) plru_nxt[1] = (upd_way == 2'd0);
    else             plru_nxt[2] = (upd_way == 2'd2);
  end

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    we_d        = we_q;
    wdata_d     = wdata_q;
    rdata_d     = rdata_q;
    maddr_d     = maddr_q;
    mwdata_d    = mwdata_q;
    fill_d      = fill_q;
    post_fill_d = post_fill_q;
    cache_we    = 1'b0;
    plru_upd    = 1'b0;
    upd_way     = hit_enc;
    case (state_q)
      S_IDLE: if (cpu_req) begin
        addr_d      = cpu_addr;
        we_d        = cpu_we;
        wdata_d     = cpu_wdata;
        post_fill_d = 1'b0;
        state_d     = S_LOOKUP;
      end
      S_LOOKUP: begin
        if (we_q) begin
          // write-through: the word always goes to memory; cache only on hit
          cache_we = cache_hit;
          plru_upd = cache_hit;
          maddr_d  = addr_q;
          mwdata_d = wdata_q;
          state_d  = S_WTHRU;
        end else if (cache_hit) begin
          plru_upd = 1'b1;
          rdata_d  = cache_rdata;
          state_d  = S_RESP;
        end else begin
          maddr_d  = {addr_q[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
          state_d  = S_REFILL;
        end
      end
      S_REFILL: if (mem_ack) begin
        fill_d  = mem_rdata;
        state_d = S_FILL;
      end
      S_FILL: begin
        plru_upd    = 1'b1;
        upd_way     = vic_enc;
        post_fill_d = 1'b1;
        state_d     = S_LOOKUP;
      end
      S_WTHRU: if (mem_ack) state_d = S_RESP;
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      we_q        <= 1'b0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      maddr_q     <= '0;
      mwdata_q    <= '0;
      fill_q      <= '0;
      post_fill_q <= 1'b0;
      plru_q      <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      we_q        <= we_d;
      wdata_q     <= wdata_d;
      rdata_q     <= rdata_d;
      maddr_q     <= maddr_d;
      mwdata_q    <= mwdata_d;
      fill_q      <= fill_d;
      post_fill_q <= post_fill_d;
      if (plru_upd) plru_q[idx] <= plru_nxt;
    end
  end

  assign cpu_busy        = (state_q != S_IDLE);
  assign cpu_ack         = (state_q == S_RESP);
  assign cpu_rdata       = rdata_q;
  assign cache_addr      = addr_q;
  assign cache_wdata     = wdata_q;
  assign cache_fill_we   = (state_q == S_FILL);
  assign cache_fill_data = fill_q;
  assign lru_way         = 4'b0001 << vic_enc;
  assign mem_req         = (state_q == S_REFILL) || (state_q == S_WTHRU);
  assign mem_we          = (state_q == S_WTHRU);
  assign mem_addr        = maddr_q;
  assign mem_wdata       = mwdata_q;

`ifdef CACHE_STATS_EN
  logic [31:0] hits_q, misses_q;
  always_ff @(posedge clk) begin
    if (reset) begin
      hits_q   <= '0;
      misses_q <= '0;
    end else if (state_q == S_LOOKUP && !post_fill_q) begin
      if (cache_hit && hits_q != '1)       hits_q   <= hits_q + 32'd1;
      if (!cache_hit && misses_q != '1)    misses_q <= misses_q + 32'd1;
    end
  end
  assign stat_hits   = hits_q;
  assign stat_misses = misses_q;
`endif

endmodule

// File: tb/tb_cache_controller.sv
// Bench for cache_controller: behavioural cache array and line memory around
// the DUT, scoreboard of expected load data / hit latency popped on cpu_ack,
// and a queue of expected victims popped on every fill pulse.
module tb_cache_controller;
  logic         clk = 1'b0, reset = 1'b1;
  logic         cpu_req = 1'b0, cpu_we = 1'b0;
  logic [31:0]  cpu_addr = '0, cpu_wdata = '0;
  logic         cpu_busy, cpu_ack;
  logic [31:0]  cpu_rdata, cache_addr, cache_wdata;
  logic         cache_we, cache_fill_we;
  logic [511:0] cache_fill_data;
  logic [3:0]   lru_way;
  logic         cache_hit;
  logic [3:0]   hit_way;
  logic [31:0]  cache_rdata;
  logic         mem_req, mem_we;
  logic [31:0]  mem_addr, mem_wdata;
  logic         mem_ack = 1'b0;
  logic [511:0] mem_rdata = '0;
`ifdef CACHE_STATS_EN
  logic [31:0]  stat_hits, stat_misses;
`endif

  cache_controller dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_busy(cpu_busy), .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
    .cache_addr(cache_addr), .cache_wdata(cache_wdata), .cache_we(cache_we),
    .cache_fill_we(cache_fill_we), .cache_fill_data(cache_fill_data), .lru_way(lru_way),
    .cache_hit(cache_hit), .hit_way(hit_way), .cache_rdata(cache_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata)
`ifdef CACHE_STATS_EN
    , .stat_hits(stat_hits), .stat_misses(stat_misses)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_bad = 0;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- line memory ----------------
  logic [31:0] wr_mem [logic [31:0]];
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [31:0] wa;
    wa = {a[31:2], 2'b00};
    if (wr_mem.exists(wa)) return wr_mem[wa];
    return wa ^ 32'hDEADBEAF;   // word at 0x40 reads 0xDEADBEEF
  endfunction

  int          mem_cnt = 0, n_rd = 0, n_wr = 0;
  logic        mem_hold = 1'b0;
  logic [31:0] last_rd = '0, last_wa = '0, last_wd = '0;
  always @(negedge clk) begin
    if (mem_ack) mem_ack = 1'b0;
    else if (reset || !mem_req || mem_hold) mem_cnt = 0;
    else if (mem_cnt < 2) mem_cnt++;
    else begin
      mem_cnt = 0;
      mem_ack = 1'b1;
      if (mem_we) begin
        wr_mem[{mem_addr[31:2], 2'b00}] = mem_wdata;
        last_wa = mem_addr; last_wd = mem_wdata; n_wr++;
      end else begin
        last_rd = mem_addr; n_rd++;
        for (int i = 0; i < 16; i++) mem_rdata[i*32 +: 32] = mem_word(mem_addr + 32'(i*4));
      end
    end
  end

  // ---------------- cache array ----------------
  bit        cval [128][4];
  bit [18:0] ctag [128][4];
  bit [31:0] cdat [128][4][16];
  logic [6:0] c_idx;
  assign c_idx = cache_addr[12:6];

  always_comb begin
    cache_hit = 1'b0; hit_way = '0; cache_rdata = '0;
    for (int w = 3; w >= 0; w--)
      if (cval[c_idx][w] && ctag[c_idx][w] == cache_addr[31:13]) begin
        hit_way[w] = 1'b1; cache_hit = 1'b1;
        cache_rdata = cdat[c_idx][w][cache_addr[5:2]];
      end
  end

  always @(posedge clk) begin
    if (cache_fill_we)
      for (int w = 0; w < 4; w++) if (lru_way[w]) begin
        cval[c_idx][w] <= 1'b1;
        ctag[c_idx][w] <= cache_addr[31:13];
        for (int i = 0; i < 16; i++) cdat[c_idx][w][i] <= cache_fill_data[i*32 +: 32];
      end
    if (cache_we)
      for (int w = 0; w < 4; w++) if (hit_way[w]) cdat[c_idx][w][cache_addr[5:2]] <= cache_wdata;
  end

  // ---------------- scoreboard ----------------
  typedef struct {
    logic        we;
    logic [31:0] rdata;
    longint      t_ack;   // 0 = latency not checked
  } exp_t;
  exp_t       sb[$];
  logic [3:0] vq[$];
  exp_t       e_m;
  int         n_cwe = 0;

  always @(negedge clk) begin
    if (cache_we) n_cwe++;
    if (cpu_ack) begin
      if (sb.size() == 0) check("spurious_ack", 1, 0);
      else begin
        e_m = sb.pop_front();
        if (!e_m.we) check("load_rdata", cpu_rdata, e_m.rdata);
        if (e_m.t_ack != 0) check("hit_latency", $time, e_m.t_ack);
      end
    end
    if (cache_fill_we) begin
      if (vq.size() == 0) check("unexpected_fill", 1, 0);
      else check("victim", lru_way, vq.pop_front());
    end
  end

  task automatic do_req(input logic we, input logic [31:0] a, input logic [31:0] d,
                        input logic hit_lat, input logic [3:0] vict);
    exp_t e;
    int   k;
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = d;
    e.we = we;
    e.rdata = we ? 32'h0 : mem_word(a);
    e.t_ack = hit_lat ? longint'($time) + 20 : 0;
    if (vict != 4'b0) vq.push_back(vict);
    sb.push_back(e);
    @(negedge clk);
    cpu_req = 1'b0;
    k = 0;
    while (sb.size() != 0 && k < 200) begin
      @(negedge clk); #1; k++;
    end
    if (sb.size() != 0) begin
      check("ack_timeout", 0, 1);
      sb.delete();
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  int cw, nw, nr, k;
`ifdef CACHE_STATS_EN
  logic [31:0] h0, m0;
`endif

  initial begin
    repeat (3) @(negedge clk);
    check("rst_busy", cpu_busy, 0);
    check("rst_ack", cpu_ack, 0);
    check("rst_mem_req", mem_req, 0);
    check("rst_fill_we", cache_fill_we, 0);
    check("rst_lru", lru_way, 4'b0001);
    check("rst_rdata", cpu_rdata, 0);
    check("rst_mem_addr", mem_addr, 0);
    reset = 1'b0;

    // first miss, then hits on the filled line
    nr = n_rd;
    do_req(1'b0, 32'h40, 0, 1'b0, 4'b0001);
    check("t1_rd_addr", last_rd, 32'h40);
    check("t1_rd_count", n_rd - nr, 1);
    check("t1_rdata", cpu_rdata, 32'hDEADBEEF);
    do_req(1'b0, 32'h44, 0, 1'b1, 4'b0);
    do_req(1'b0, 32'h2040, 0, 1'b0, 4'b0100);
    check("t2_rd_addr", last_rd, 32'h2040);

    // set 5: fill all ways, hit way0, next victim is way2
    do_req(1'b0, 32'h0140, 0, 1'b0, 4'b0001);
    do_req(1'b0, 32'h2140, 0, 1'b0, 4'b0100);
    do_req(1'b0, 32'h4140, 0, 1'b0, 4'b0010);
    do_req(1'b0, 32'h6140, 0, 1'b0, 4'b1000);
    do_req(1'b0, 32'h0148, 0, 1'b1, 4'b0);
    do_req(1'b0, 32'h8140, 0, 1'b0, 4'b0100);

    // store hit: one cache word write plus write-through
    do_req(1'b0, 32'h1004, 0, 1'b0, 4'b0001);
    cw = n_cwe; nw = n_wr;
    do_req(1'b1, 32'h1004, 32'h12345678, 1'b0, 4'b0);
    check("st_hit_cache_we", n_cwe - cw, 1);
    check("st_hit_wr_count", n_wr - nw, 1);
    check("st_hit_mem_addr", last_wa, 32'h1004);
    check("st_hit_mem_data", last_wd, 32'h12345678);
    do_req(1'b0, 32'h1004, 0, 1'b1, 4'b0);

    // store miss in set 5: no cache write, PLRU of set 5 unchanged (victim way1)
    cw = n_cwe;
    do_req(1'b1, 32'hA144, 32'hCAFEF00D, 1'b0, 4'b0);
    check("st_miss_cache_we", n_cwe - cw, 0);
    check("st_miss_mem_addr", last_wa, 32'hA144);
    check("st_miss_lru", lru_way, 4'b0010);
    do_req(1'b0, 32'hA144, 0, 1'b0, 4'b0010);

    // reset during REFILL, with a cpu_req while busy
    mem_hold = 1'b1;
    nr = n_rd;
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h4040;
    @(negedge clk);
    cpu_req = 1'b0;
    k = 0;
    while (!mem_req && k < 10) begin @(negedge clk); k++; end
    check("rr_mem_req", mem_req, 1);
    check("rr_lru_before", lru_way, 4'b0010);
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h5000;
    @(negedge clk);
    cpu_req = 1'b0;
    check("busy_mem_addr", mem_addr, 32'h4040);
    check("busy_mem_we", mem_we, 0);
    reset = 1'b1;
    @(negedge clk);
    check("rr_mem_req_drop", mem_req, 0);
    check("rr_lru_after", lru_way, 4'b0001);
    check("rr_busy", cpu_busy, 0);
`ifdef CACHE_STATS_EN
    check("rr_stat_hits", stat_hits, 0);
    check("rr_stat_misses", stat_misses, 0);
`endif
    reset = 1'b0; mem_hold = 1'b0;
    repeat (10) @(negedge clk);
    check("rr_no_mem_rd", n_rd - nr, 0);

    // stats traffic: 3 load hits, 2 load misses
`ifdef CACHE_STATS_EN
    h0 = stat_hits; m0 = stat_misses;
`endif
    do_req(1'b0, 32'h0040, 0, 1'b1, 4'b0);
    do_req(1'b0, 32'h0044, 0, 1'b1, 4'b0);
    do_req(1'b0, 32'h2040, 0, 1'b1, 4'b0);
    do_req(1'b0, 32'h04C0, 0, 1'b0, 4'b0001);
    do_req(1'b0, 32'h20C0, 0, 1'b0, 4'b0001);
`ifdef CACHE_STATS_EN
    check("stat_hits", stat_hits - h0, 3);
    check("stat_misses", stat_misses - m0, 2);
`endif

    repeat (3) @(negedge clk);
    check("victims_left", vq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
